exu_muldiv_seq: RTL and testbench

Iterative sequencer for the RV32M multiply/divide/remainder operations that the execute stage's single-cycle ALU does not implement. It accepts one operation at a time from the EXU over a valid/ready handshake and runs a radix-2 shift-add multiply or restoring divide on operand magnitudes over 32 iterations. It then applies the sign and special-case fix-up and holds the 32-bit result until the EXU accepts it. It sits beside the ALU result mux inside the EXU; the EXU stalls its own send handshake while `busy` is high.

---
 rtl/exu_muldiv_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_exu_muldiv_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv_seq.sv
// rtl/exu_muldiv_seq.sv - iterative RV32M multiply/divide sequencer; optional early-out via EXU_MULDIV_EARLY_OUT_EN
module exu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic [1:0]  state;
  logic [5:0]  cnt;

  // Captured operation context
  logic [2:0]  op_q;
  logic        neg_q;       // operand signs differ (product / quotient sign)
  logic        src1_neg_q;  // dividend sign, gives the remainder sign
  logic        div_zero_q;
  logic [31:0] src1_q;      // raw dividend, returned by REM on divide by zero
  logic [31:0] opnd_q;      // multiplicand magnitude or divisor magnitude

  // Iteration state: acc_q for multiply, rem_q/quot_q for divide
  logic [63:0] acc_q;
  logic [31:0] rem_q;
  logic [31:0] quot_q;      // starts as dividend magnitude, shifts into quotient

  logic [31:0] result_q;

  // Request decode (feeds registers only, never an output)
  logic        accept;
  logic        in_is_div;
  logic        s1_signed;
  logic        s2_signed;
  logic        s1_neg;
  logic        s2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;

  // Per-iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] acc_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_next;
  logic [31:0] quot_next;

  // Sign fix-up
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_value;

`ifdef EXU_MULDIV_EARLY_OUT_EN
  logic        early_hit;
  logic [31:0] early_value;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;

  // Operand signedness and magnitudes for an incoming request
  always_comb begin
    accept    = in_valid && (state == ST_IDLE) && !kill;
    in_is_div = op[2];
    s1_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV) || (op == OP_REM);
    s2_signed = (op == OP_MUL) || (op == OP_MULH) ||
                (op == OP_DIV) || (op == OP_REM);
    s1_neg    = s1_signed && src1[31];
    s2_neg    = s2_signed && src2[31];
    mag1      = s1_neg ? (32'd0 - src1) : src1;
    mag2      = s2_neg ? (32'd0 - src2) : src2;
  end

`ifdef EXU_MULDIV_EARLY_OUT_EN
  // Trivial operations whose result is known at accept time
  always_comb begin
    early_hit   = 1'b0;
    early_value = 32'd0;
    if (in_is_div) begin
      early_hit   = (src2 == 32'd0);
      early_value = op[1] ? src1 : 32'hFFFF_FFFF;
    end else begin
      early_hit   = (src1 == 32'd0) || (src2 == 32'd0);
      early_value = 32'd0;
    end
  end
`endif

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    acc_next  = {mul_sum, acc_q[31:1]};
    div_shift = {rem_q, quot_q[31]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // Partial remainder stays below the divisor, so 32 bits hold it after the step
    rem_next  = div_ge ? (div_shift[31:0] - opnd_q) : div_shift[31:0];
    quot_next = {quot_q[30:0], div_ge};
  end

  // Sign and divide-by-zero fix-up of the magnitude result
  always_comb begin
    prod_fix  = neg_q ? (64'd0 - acc_q) : acc_q;
    quot_fix  = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quot_q) : quot_q);
    rem_fix   = div_zero_q ? src1_q : (src1_neg_q ? (32'd0 - rem_q) : rem_q);
    fix_value = 32'd0;
    case (op_q)
      OP_MUL:                       fix_value = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_value = prod_fix[63:32];
      OP_DIV, OP_DIVU:              fix_value = quot_fix;
      OP_REM, OP_REMU:              fix_value = rem_fix;
      default:                      fix_value = 32'd0;
    endcase
  end

  // Sequencer FSM and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt <= 6'd0;
`ifdef EXU_MULDIV_EARLY_OUT_EN
            state <= early_hit ? ST_DONE : ST_CALC;
`else
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (kill) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
          end else begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state <= kill ? ST_IDLE : ST_DONE;
          cnt   <= 6'd0;
        end
        ST_DONE: begin
          if (kill || out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 6'd0;
        end
      endcase
    end
  end

  // Operand capture on accept, then one multiply and divide step per CALC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      src1_neg_q <= 1'b0;
      div_zero_q <= 1'b0;
      src1_q     <= 32'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
    end else if (accept) begin
      op_q       <= op;
      neg_q      <= s1_neg ^ s2_neg;
      src1_neg_q <= s1_neg;
      div_zero_q <= (src2 == 32'd0);
      src1_q     <= src1;
      opnd_q     <= in_is_div ? mag2 : mag1;
      acc_q      <= {32'd0, mag2};
      rem_q      <= 32'd0;
      quot_q     <= mag1;
    end else if (state == ST_CALC) begin
      acc_q  <= acc_next;
      rem_q  <= rem_next;
      quot_q <= quot_next;
    end
  end

  // Result register: written in FIX (unless killed) or on an early-out accept
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 32'd0;
    end else if ((state == ST_FIX) && !kill) begin
      result_q <= fix_value;
`ifdef EXU_MULDIV_EARLY_OUT_EN
    end else if (accept && early_hit) begin
      result_q <= early_value;
`endif
    end
  end

endmodule

// File: tb/tb_exu_muldiv_seq.sv
// tb/tb_exu_muldiv_seq.sv - randomized self-checking bench for exu_muldiv_seq
module tb_exu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  exu_muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the RV32M definitions
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] pv;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin pv = 64'(sa * sb); return pv[31:0];  end
      3'd1: begin pv = 64'(sa * sb); return pv[63:32]; end
      3'd2: begin pv = 64'(sa * ub); return pv[63:32]; end
      3'd3: begin pv = 64'(ua * ub); return pv[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef EXU_MULDIV_EARLY_OUT_EN
    if (o[2] && b == 32'd0) return 1;
    if (!o[2] && (a == 32'd0 || b == 32'd0)) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, check timing/result, optionally stall, then deliver
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat;
    logic        ready_leak;
    exp = ref_model(o, a, b);
    check("idle_before_op", {31'd0, in_ready}, 32'd1);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom; op = 3'($urandom_range(0, 7));
    lat = 1;
    ready_leak = 1'b0;
    if (!out_valid) check("busy_after_accept", {30'd0, in_ready, busy}, 32'd1);
    while (!out_valid && lat < 60) begin
      if (in_ready || !busy) ready_leak = 1'b1;
      step();
      lat++;
    end
    check($sformatf("latency op%0d", o), 32'(lat), 32'(ref_latency(o, a, b)));
    check($sformatf("result op%0d %h %h", o, a, b), result, exp);
    check("no_ready_while_busy", {31'd0, ready_leak}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("bp_hold", {30'd0, out_valid, in_ready}, 32'd2);
      check("bp_result", result, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("delivered", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  // Start an op and abort it by kill (use_rst=0) or reset (use_rst=1) in CALC cycle k
  task automatic abort_op(input logic use_rst, input int k);
    logic seen;
    op = 3'd4; src1 = 32'd1000; src2 = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < k; i++) step();
    check("still_calc", {31'd0, busy}, 32'd1);
    if (use_rst) rst = 1'b1; else kill = 1'b1;
    step();
    rst = 1'b0; kill = 1'b0;
    check(use_rst ? "rst_outputs" : "kill_outputs",
          {29'd0, in_ready, busy, out_valid}, 32'd4);
    if (use_rst) check("rst_result", result, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check(use_rst ? "rst_no_pulse" : "kill_no_pulse", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
    kill = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("reset_outputs", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("reset_result", result, 32'd0);

    // kill in IDLE blocks the accept
    op = 3'd0; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1; kill = 1'b1;
    step();
    in_valid = 1'b0; kill = 1'b0;
    check("idle_kill_blocks", {30'd0, in_ready, busy}, 32'd2);

    do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5);
    do_op(3'd5, 32'h0000_1234, 32'd0,         0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd0,         0);
    do_op(3'd0, 32'd0,         32'h1234_5678, 0);

    abort_op(1'b0, 10);
    abort_op(1'b1, 20);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
